// File: rtl/ex_stage_if.sv
// ID/EX to EX/MEM bundle for the execute stage: decoded operands/control in, registered
// results/control and the upstream stall out.
interface ex_stage_if;
  logic        ID_EX_Valid;
  logic [31:0] ID_EX_ReadData1;
  logic [31:0] ID_EX_ReadData2;
  logic [31:0] ID_EX_Imm;
  logic        ID_EX_ALUSrc;
  logic [3:0]  ID_EX_ALUOp;
  logic [4:0]  ID_EX_WriteReg;
  logic        ID_EX_MemRead;
  logic        ID_EX_MemWrite;
  logic        ID_EX_MemToReg;
  logic        ID_EX_RegWrite;

  logic [31:0] EX_MEM_ALUResult;
  logic [31:0] EX_MEM_ReadData2;
  logic [4:0]  EX_MEM_WriteReg;
  logic        EX_MEM_MemRead;
  logic        EX_MEM_MemWrite;
  logic        EX_MEM_MemToReg;
  logic        EX_MEM_RegWrite;
  logic        EX_Stall;

  modport master (
    output ID_EX_Valid, ID_EX_ReadData1, ID_EX_ReadData2, ID_EX_Imm, ID_EX_ALUSrc,
           ID_EX_ALUOp, ID_EX_WriteReg, ID_EX_MemRead, ID_EX_MemWrite,
           ID_EX_MemToReg, ID_EX_RegWrite,
    input  EX_MEM_ALUResult, EX_MEM_ReadData2, EX_MEM_WriteReg, EX_MEM_MemRead,
           EX_MEM_MemWrite, EX_MEM_MemToReg, EX_MEM_RegWrite, EX_Stall
  );

  modport slave (
    input  ID_EX_Valid, ID_EX_ReadData1, ID_EX_ReadData2, ID_EX_Imm, ID_EX_ALUSrc,
           ID_EX_ALUOp, ID_EX_WriteReg, ID_EX_MemRead, ID_EX_MemWrite,
           ID_EX_MemToReg, ID_EX_RegWrite,
    output EX_MEM_ALUResult, EX_MEM_ReadData2, EX_MEM_WriteReg, EX_MEM_MemRead,
           EX_MEM_MemWrite, EX_MEM_MemToReg, EX_MEM_RegWrite, EX_Stall
  );
endinterface

// File: rtl/ex_stage.sv
// Execute stage: single-cycle ALU plus, when EX_MUL_EN is defined, an iterative shift-add
// multiplier (MUL_STEP bits per cycle) that stalls upstream until the product is ready.
module ex_stage #(
  parameter int MUL_STEP = 1
) (
  input  logic      clk,
  input  logic      rst,
  ex_stage_if.slave bus_io
);
  localparam logic [3:0] OP_ADD = 4'b0000;
  localparam logic [3:0] OP_SUB = 4'b0001;
  localparam logic [3:0] OP_AND = 4'b0010;
  localparam logic [3:0] OP_OR  = 4'b0011;
  localparam logic [3:0] OP_XOR = 4'b0100;
  localparam logic [3:0] OP_SLT = 4'b0101;
  localparam logic [3:0] OP_SLL = 4'b0110;
  localparam logic [3:0] OP_SRL = 4'b0111;

  typedef struct packed {
    logic [4:0] wreg;
    logic       mem_read;
    logic       mem_write;
    logic       mem_to_reg;
    logic       reg_write;
  } ctrl_t;

  typedef struct packed {
    logic [31:0] result;
    logic [31:0] store;
    ctrl_t       ctrl;
  } exmem_t;

  if (!(MUL_STEP == 1 || MUL_STEP == 2 || MUL_STEP == 4 || MUL_STEP == 8)) begin : g_bad_step
    $error("ex_stage: MUL_STEP must be 1, 2, 4 or 8");
  end

  logic [31:0] op_a, op_b, alu_res;
  exmem_t      alu_pkt, exmem_d, exmem_q;
  logic        stall;

  assign op_a = bus_io.ID_EX_ReadData1;
  assign op_b = bus_io.ID_EX_ALUSrc ? bus_io.ID_EX_Imm : bus_io.ID_EX_ReadData2;

  // MUL lands in default here; the multiplier path (if built) supplies its result.
  always_comb begin
    alu_res = '0;
    case (bus_io.ID_EX_ALUOp)
      OP_ADD:  alu_res = op_a + op_b;
      OP_SUB:  alu_res = op_a - op_b;
      OP_AND:  alu_res = op_a & op_b;
      OP_OR:   alu_res = op_a | op_b;
      OP_XOR:  alu_res = op_a ^ op_b;
      OP_SLT:  alu_res = {31'd0, $signed(op_a) < $signed(op_b)};
      OP_SLL:  alu_res = op_a << op_b[4:0];
      OP_SRL:  alu_res = op_a >> op_b[4:0];
      default: alu_res = '0;
    endcase
  end

  always_comb begin
    alu_pkt                 = '0;
    alu_pkt.result          = alu_res;
    alu_pkt.store           = bus_io.ID_EX_ReadData2;
    alu_pkt.ctrl.wreg       = bus_io.ID_EX_WriteReg;
    alu_pkt.ctrl.mem_read   = bus_io.ID_EX_MemRead;
    alu_pkt.ctrl.mem_write  = bus_io.ID_EX_MemWrite;
    alu_pkt.ctrl.mem_to_reg = bus_io.ID_EX_MemToReg;
    alu_pkt.ctrl.reg_write  = bus_io.ID_EX_RegWrite;
  end

`ifdef EX_MUL_EN
  localparam logic [3:0] OP_MUL = 4'b1000;
  localparam int         N      = 32 / MUL_STEP;
  localparam int         CW     = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [31:0]   acc_q, acc_d, acc_step;
  logic [31:0]   mcand_q, mcand_d, mplier_q, mplier_d;
  exmem_t        mpkt_q, mpkt_d;
  logic          is_mul;

  assign is_mul = bus_io.ID_EX_Valid && (bus_io.ID_EX_ALUOp == OP_MUL);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      mpkt_q   <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      mpkt_q   <= mpkt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (is_mul) state_d = S_BUSY;
      S_BUSY:  if (!bus_io.ID_EX_Valid) state_d = S_IDLE;
               else if (cnt_q == LAST) state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Retire MUL_STEP multiplier bits: low bits of mplier select shifted copies of mcand.
  always_comb begin
    acc_step = acc_q;
    for (int i = 0; i < MUL_STEP; i++)
      if (mplier_q[i]) acc_step = acc_step + (mcand_q << i);
  end

  always_comb begin
    exmem_d  = '0;
    stall    = 1'b0;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    mpkt_d   = mpkt_q;
    case (state_q)
      S_IDLE: begin
        if (is_mul) begin
          stall    = 1'b1;
          cnt_d    = '0;
          acc_d    = '0;
          mcand_d  = op_a;
          mplier_d = op_b;
          mpkt_d   = alu_pkt;
        end else if (bus_io.ID_EX_Valid) begin
          exmem_d = alu_pkt;
        end
      end
      S_BUSY: begin
        stall = 1'b1;
        if (bus_io.ID_EX_Valid) begin
          acc_d    = acc_step;
          mcand_d  = mcand_q << MUL_STEP;
          mplier_d = mplier_q >> MUL_STEP;
          cnt_d    = cnt_q + 1'b1;
        end
      end
      S_DONE: begin
        // A flush here drops the finished product rather than committing it.
        if (bus_io.ID_EX_Valid) begin
          exmem_d        = mpkt_q;
          exmem_d.result = acc_q;
        end
      end
      default: ;
    endcase
  end
`else
  always_comb begin
    stall   = 1'b0;
    exmem_d = bus_io.ID_EX_Valid ? alu_pkt : '0;
  end
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) exmem_q <= '0;
    else     exmem_q <= exmem_d;
  end

  assign bus_io.EX_MEM_ALUResult = exmem_q.result;
  assign bus_io.EX_MEM_ReadData2 = exmem_q.store;
  assign bus_io.EX_MEM_WriteReg  = exmem_q.ctrl.wreg;
  assign bus_io.EX_MEM_MemRead   = exmem_q.ctrl.mem_read;
  assign bus_io.EX_MEM_MemWrite  = exmem_q.ctrl.mem_write;
  assign bus_io.EX_MEM_MemToReg  = exmem_q.ctrl.mem_to_reg;
  assign bus_io.EX_MEM_RegWrite  = exmem_q.ctrl.reg_write;
  assign bus_io.EX_Stall         = stall;
endmodule

// File: tb/tb_ex_stage.sv
// Directed bench for ex_stage: ALU ops, pass-through, bubbles, async reset, and (with
// EX_MUL_EN) multiply latency, flush and back-to-back behaviour.
module tb_ex_stage;
  localparam int MUL_STEP = 1;
  localparam int N        = 32 / MUL_STEP;

  localparam logic [3:0] ADD = 4'h0, SUB = 4'h1, AND_ = 4'h2, OR_ = 4'h3, XOR_ = 4'h4;
  localparam logic [3:0] SLT = 4'h5, SLL = 4'h6, SRL = 4'h7, MUL = 4'h8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  ex_stage_if bus ();
  ex_stage #(.MUL_STEP(MUL_STEP)) dut (.clk(clk), .rst(rst), .bus_io(bus));

  int n_checks = 0;
  int n_fail   = 0;

  // {ALUResult, ReadData2, WriteReg, MemRead, MemWrite, MemToReg, RegWrite}
  logic [73:0] out_vec;
  assign out_vec = {bus.EX_MEM_ALUResult, bus.EX_MEM_ReadData2, bus.EX_MEM_WriteReg,
                    bus.EX_MEM_MemRead, bus.EX_MEM_MemWrite, bus.EX_MEM_MemToReg,
                    bus.EX_MEM_RegWrite};

  logic [3:0]  vop[16] = '{ADD, ADD, SUB, AND_, OR_, XOR_, SLT, SLT, SLT, SLT,
                           SRL, SLL, SLL, SRL, 4'h9, 4'hF};
  logic [31:0] va[16]  = '{32'h7FFFFFFF, 32'hFFFFFFFF, 32'h5, 32'hF0F0FF00, 32'hF0F0FF00,
                           32'hF0F0FF00, 32'hFFFFFFFE, 32'h1, 32'h3, 32'h80000000,
                           32'hFFFFFFFE, 32'h1, 32'h1, 32'h80000000, 32'h5, 32'hFFFFFFFF};
  logic [31:0] vb[16]  = '{32'h1, 32'h2, 32'h7, 32'h0FF0F0F0, 32'h0FF0F0F0, 32'h0FF0F0F0,
                           32'h1, 32'hFFFFFFFE, 32'h3, 32'h7FFFFFFF, 32'h4, 32'h1F,
                           32'h21, 32'h1F, 32'h6, 32'hFFFFFFFF};
  logic [31:0] ve[16]  = '{32'h80000000, 32'h1, 32'hFFFFFFFE, 32'h00F0F000, 32'hFFF0FFF0,
                           32'hFF000FF0, 32'h1, 32'h0, 32'h0, 32'h1, 32'h0FFFFFFF,
                           32'h80000000, 32'h2, 32'h1, 32'h0, 32'h0};

  task automatic drive(input logic v, input logic [3:0] op, input logic [31:0] a,
                       input logic [31:0] rd2, input logic [31:0] imm, input logic src,
                       input logic [4:0] wr, input logic [3:0] ctl);
    bus.ID_EX_Valid     = v;
    bus.ID_EX_ALUOp     = op;
    bus.ID_EX_ReadData1 = a;
    bus.ID_EX_ReadData2 = rd2;
    bus.ID_EX_Imm       = imm;
    bus.ID_EX_ALUSrc    = src;
    bus.ID_EX_WriteReg  = wr;
    {bus.ID_EX_MemRead, bus.ID_EX_MemWrite, bus.ID_EX_MemToReg, bus.ID_EX_RegWrite} = ctl;
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    drive(1'b1, ADD, 32'h5, 32'h6, 32'h7, 1'b0, 5'd9, 4'b0001);
    tick;
    tick;
    n_checks++;
    if (out_vec !== 74'd0) begin
      n_fail++; $display("FAIL reset_outputs got %h want 0", out_vec);
    end
    n_checks++;
    if (bus.EX_Stall !== 1'b0) begin
      n_fail++; $display("FAIL reset_stall got %b want 0", bus.EX_Stall);
    end
    drive(1'b0, ADD, '0, '0, '0, 1'b0, 5'd0, 4'b0000);
    rst = 1'b0;
    tick;
  endtask

  task automatic test_add;
    drive(1'b1, ADD, 32'h8, 32'h0, 32'h8, 1'b1, 5'd3, 4'b0001);
    #1;
    n_checks++;
    if (bus.EX_Stall !== 1'b0) begin
      n_fail++; $display("FAIL add_stall got %b want 0", bus.EX_Stall);
    end
    tick;
    n_checks++;
    if (out_vec !== {32'h10, 32'h0, 5'd3, 4'b0001}) begin
      n_fail++; $display("FAIL add_result got %h want %h", out_vec, {32'h10, 32'h0, 5'd3, 4'b0001});
    end
  endtask

  task automatic test_store;
    drive(1'b1, ADD, 32'h10, 32'hABCD1234, 32'h0, 1'b1, 5'd0, 4'b0100);
    tick;
    n_checks++;
    if (out_vec !== {32'h10, 32'hABCD1234, 5'd0, 4'b0100}) begin
      n_fail++; $display("FAIL store_pass got %h want %h", out_vec, {32'h10, 32'hABCD1234, 5'd0, 4'b0100});
    end
  endtask

  task automatic test_alu_ops;
    for (int i = 0; i < 16; i++) begin
      drive(1'b1, vop[i], va[i], vb[i], 32'h0, 1'b0, 5'd5, 4'b0001);
      tick;
      n_checks++;
      if (out_vec !== {ve[i], vb[i], 5'd5, 4'b0001}) begin
        n_fail++; $display("FAIL alu_op[%0d] got %h want %h", i, out_vec, {ve[i], vb[i], 5'd5, 4'b0001});
      end
    end
  endtask

  task automatic test_bubble;
    drive(1'b0, ADD, 32'h1234, 32'h55, 32'h0, 1'b0, 5'd7, 4'b1011);
    tick;
    n_checks++;
    if (out_vec !== 74'd0) begin
      n_fail++; $display("FAIL bubble got %h want 0", out_vec);
    end
  endtask

  task automatic test_async_reset;
    drive(1'b1, OR_, 32'hA5A50000, 32'h00005A5A, 32'h0, 1'b0, 5'd31, 4'b1011);
    tick;
    n_checks++;
    if (out_vec !== {32'hA5A55A5A, 32'h00005A5A, 5'd31, 4'b1011}) begin
      n_fail++; $display("FAIL pre_reset got %h want %h", out_vec, {32'hA5A55A5A, 32'h00005A5A, 5'd31, 4'b1011});
    end
    #2;
    rst = 1'b1;
    #1;
    n_checks++;
    if (out_vec !== 74'd0) begin
      n_fail++; $display("FAIL async_reset got %h want 0", out_vec);
    end
    drive(1'b0, ADD, '0, '0, '0, 1'b0, 5'd0, 4'b0000);
    #1;
    rst = 1'b0;
    tick;
  endtask

`ifdef EX_MUL_EN
  // Leaves the MUL driven after commit so a caller can present the next instruction.
  task automatic test_mul(input logic [31:0] a, input logic [31:0] b, input logic src,
                          input logic [31:0] exp, input logic [4:0] wr);
    int   stall_n = 0;
    logic bub_ok  = 1'b1;
    logic [31:0] rd2;
    rd2 = src ? 32'h55 : b;
    drive(1'b1, MUL, a, rd2, src ? b : 32'h0, src, wr, 4'b0001);
    #1;
    while (bus.EX_Stall === 1'b1 && stall_n < 4 * N) begin
      stall_n++;
      tick;
      if (out_vec !== 74'd0) bub_ok = 1'b0;
    end
    n_checks++;
    if (stall_n != N + 1) begin
      n_fail++; $display("FAIL mul_stall_cycles a=%h got %0d want %0d", a, stall_n, N + 1);
    end
    n_checks++;
    if (bub_ok !== 1'b1) begin
      n_fail++; $display("FAIL mul_bubbles a=%h got non-bubble want bubble", a);
    end
    tick;
    n_checks++;
    if (out_vec !== {exp, rd2, wr, 4'b0001}) begin
      n_fail++; $display("FAIL mul_result a=%h b=%h got %h want %h", a, b, out_vec, {exp, rd2, wr, 4'b0001});
    end
  endtask

  task automatic test_mul_vectors;
    test_mul(32'h00012345, 32'h00000100, 1'b0, 32'h01234500, 5'd4);
    test_mul(32'hFFFFFFFF, 32'h00000002, 1'b1, 32'hFFFFFFFE, 5'd6);
    test_mul(32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 32'h00000001, 5'd8);
    test_mul(32'h00000000, 32'hDEADBEEF, 1'b0, 32'h00000000, 5'd9);
    test_mul(32'h80000000, 32'h00000003, 1'b0, 32'h80000000, 5'd10);
    drive(1'b0, ADD, '0, '0, '0, 1'b0, 5'd0, 4'b0000);
    tick;
  endtask

  task automatic test_back_to_back;
    test_mul(32'h00000007, 32'h00000006, 1'b0, 32'h0000002A, 5'd11);
    test_mul(32'h00001000, 32'h00010000, 1'b0, 32'h10000000, 5'd12);
    drive(1'b0, ADD, '0, '0, '0, 1'b0, 5'd0, 4'b0000);
    tick;
    n_checks++;
    if (out_vec !== 74'd0) begin
      n_fail++; $display("FAIL b2b_no_dup got %h want 0", out_vec);
    end
  endtask

  task automatic test_flush;
    int rw_seen = 0;
    int guard   = 0;
    drive(1'b1, MUL, 32'h00012345, 32'h00000100, 32'h0, 1'b0, 5'd13, 4'b0001);
    repeat (5) tick;
    drive(1'b0, MUL, 32'h00012345, 32'h00000100, 32'h0, 1'b0, 5'd13, 4'b0001);
    tick;
    n_checks++;
    if (bus.EX_Stall !== 1'b0) begin
      n_fail++; $display("FAIL flush_stall got %b want 0", bus.EX_Stall);
    end
    repeat (N + 3) begin
      if (bus.EX_MEM_RegWrite !== 1'b0) rw_seen++;
      tick;
    end
    n_checks++;
    if (rw_seen != 0) begin
      n_fail++; $display("FAIL flush_regwrite got %0d commits want 0", rw_seen);
    end
    drive(1'b1, ADD, 32'h2, 32'h3, 32'h0, 1'b0, 5'd14, 4'b0001);
    tick;
    n_checks++;
    if (out_vec !== {32'h5, 32'h3, 5'd14, 4'b0001}) begin
      n_fail++; $display("FAIL flush_add got %h want %h", out_vec, {32'h5, 32'h3, 5'd14, 4'b0001});
    end
    // Flush arriving in the final (non-stalling) cycle must drop the product.
    drive(1'b1, MUL, 32'h3, 32'h5, 32'h0, 1'b0, 5'd15, 4'b0001);
    #1;
    while (bus.EX_Stall === 1'b1 && guard < 4 * N) begin
      guard++;
      tick;
    end
    drive(1'b0, ADD, '0, '0, '0, 1'b0, 5'd0, 4'b0000);
    tick;
    n_checks++;
    if (out_vec !== 74'd0) begin
      n_fail++; $display("FAIL flush_done got %h want 0", out_vec);
    end
  endtask

  task automatic test_reset_mid_mul;
    drive(1'b1, MUL, 32'h00012345, 32'h00000100, 32'h0, 1'b0, 5'd16, 4'b0001);
    repeat (10) tick;
    rst = 1'b1;
    drive(1'b0, ADD, '0, '0, '0, 1'b0, 5'd0, 4'b0000);
    #1;
    n_checks++;
    if (bus.EX_Stall !== 1'b0 || out_vec !== 74'd0) begin
      n_fail++; $display("FAIL mid_mul_reset got stall=%b out=%h want 0/0", bus.EX_Stall, out_vec);
    end
    #1;
    rst = 1'b0;
    tick;
    test_mul(32'h00012345, 32'h00000100, 1'b0, 32'h01234500, 5'd17);
    drive(1'b0, ADD, '0, '0, '0, 1'b0, 5'd0, 4'b0000);
    tick;
  endtask
`else
  task automatic test_mul_disabled;
    drive(1'b1, MUL, 32'h3, 32'h5, 32'h0, 1'b0, 5'd7, 4'b0001);
    #1;
    n_checks++;
    if (bus.EX_Stall !== 1'b0) begin
      n_fail++; $display("FAIL mul_off_stall got %b want 0", bus.EX_Stall);
    end
    tick;
    n_checks++;
    if (out_vec !== {32'h0, 32'h5, 5'd7, 4'b0001}) begin
      n_fail++; $display("FAIL mul_off_result got %h want %h", out_vec, {32'h0, 32'h5, 5'd7, 4'b0001});
    end
    drive(1'b0, ADD, '0, '0, '0, 1'b0, 5'd0, 4'b0000);
    tick;
  endtask
`endif

  initial begin
    #1_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    drive(1'b0, ADD, '0, '0, '0, 1'b0, 5'd0, 4'b0000);
    test_reset;
    test_add;
    test_store;
    test_alu_ops;
    test_bubble;
    test_async_reset;
`ifdef EX_MUL_EN
    test_mul_vectors;
    test_back_to_back;
    test_flush;
    test_reset_mid_mul;
`else
    test_mul_disabled;
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
